timer_input_conditioner: RTL and testbench

TIMER_INPUT_CONDITIONER -- requirements
Module: timer_input_conditioner

---
 rtl/timer_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 95 +++++++++
 rtl/timer_input_conditioner.sv | 124 ++++++++++++
 tb/tb_timer_input_conditioner.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared defaults and debounce state encoding for the timer input conditioner.
package timer_pkg;

   localparam int unsigned CLK_HZ          = 50_000_000;
   localparam int unsigned TICK_DIV        = CLK_HZ;
   localparam int unsigned DEBOUNCE_CYCLES = 500_000;
   localparam int unsigned REPEAT_DELAY    = 25_000_000;
   localparam int unsigned REPEAT_RATE     = 5_000_000;

   typedef enum logic {
      IDLE     = 1'b0,
      COUNTING = 1'b1
   } db_state_t;

   // Width of a counter that runs 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw asynchronous input: two-flop synchronizer, debounce filter,
// and one-cycle strobes that coincide with the first cycle of the new level.
module btn_debounce
   import timer_pkg::*;
#(
   parameter int unsigned CYCLES = DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   localparam int unsigned   CW       = cnt_width(CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   db_state_t     r_state;
   db_state_t     w_state_nx;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nx;
   logic          r_level;
   logic          w_level_nx;
   logic          r_rise;
   logic          r_fall;
   logic          w_diff;

   assign w_diff = r_sync2 ^ r_level;

   // NOTE: sequential state uses <= so every flop samples pre-edge values;
   // blocking here would let r_sync2 see this cycle's r_sync1 and collapse the synchronizer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_level <= w_level_nx;
         r_rise  <= w_level_nx & ~r_level;
         r_fall  <= ~w_level_nx & r_level;
      end
   end

   // r_cnt holds the number of consecutive disagreeing samples already seen.
   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_level_nx = r_level;
      case (r_state)
         IDLE: begin
            if (w_diff) begin
               if (r_cnt == CNT_LAST) begin
                  w_level_nx = r_sync2;
               end else begin
                  w_state_nx = COUNTING;
                  w_cnt_nx   = r_cnt + CW'(1);
               end
            end
         end
         COUNTING: begin
            if (!w_diff) begin
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_level_nx = r_sync2;
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
            end else begin
               w_cnt_nx   = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule

// File: rtl/timer_input_conditioner.sv
// Conditions the timer's raw buttons/switch into strobes and generates the countdown tick.
// Auto-repeat of inc_pulse is built only when TIMER_AUTO_REPEAT_EN is defined.
module timer_input_conditioner
   import timer_pkg::cnt_width;
#(
   parameter int unsigned TICK_DIV        = timer_pkg::TICK_DIV,
   parameter int unsigned DEBOUNCE_CYCLES = timer_pkg::DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = timer_pkg::REPEAT_DELAY,
   parameter int unsigned REPEAT_RATE     = timer_pkg::REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_inc,
   input  logic sw_forward,
   input  logic btn_clr,
   output logic tick,
   output logic inc_pulse,
   output logic forward,
   output logic load_pulse,
   output logic clr_pulse
);

   localparam int unsigned   PW         = cnt_width(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   if (TICK_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
      $error("timer_input_conditioner: TICK_DIV must be >= 2 and other periods >= 1");
   end

   logic w_inc_level, w_inc_rise, w_inc_fall;
   logic w_fwd_level, w_fwd_rise, w_fwd_fall;
   logic w_clr_level, w_clr_rise, w_clr_fall;
   logic w_unused;
   logic w_wrap;
   logic w_rep_fire;

   logic [PW-1:0] r_presc;
   logic          r_tick;
   logic          r_inc;
   logic          r_load;
   logic          r_clr;

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
      .clk(clk), .reset(reset), .i_raw(btn_inc),
      .o_level(w_inc_level), .o_rise(w_inc_rise), .o_fall(w_inc_fall)
   );

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_fwd (
      .clk(clk), .reset(reset), .i_raw(sw_forward),
      .o_level(w_fwd_level), .o_rise(w_fwd_rise), .o_fall(w_fwd_fall)
   );

   btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clk(clk), .reset(reset), .i_raw(btn_clr),
      .o_level(w_clr_level), .o_rise(w_clr_rise), .o_fall(w_clr_fall)
   );

   assign w_unused = ^{w_inc_level, w_inc_fall, w_fwd_rise, w_clr_level, w_clr_fall};

   // Fall strobe clears the prescaler so it reads 0 during load_pulse: first tick TICK_DIV later.
   assign w_wrap = (r_presc == PRESC_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_presc <= '0;
         r_tick  <= 1'b0;
         r_inc   <= 1'b0;
         r_load  <= 1'b0;
         r_clr   <= 1'b0;
      end else begin
         r_presc <= (w_fwd_level || w_fwd_fall || w_wrap) ? '0 : r_presc + PW'(1);
         r_tick  <= w_wrap & ~w_fwd_level & ~w_clr_rise;
         r_inc   <= (w_inc_rise & w_fwd_level) | w_rep_fire;
         r_load  <= w_fwd_fall;
         r_clr   <= w_clr_rise;
      end
   end

`ifdef TIMER_AUTO_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW      = cnt_width(REP_MAX);

   logic [RW-1:0] r_rep_cnt;
   logic          r_rep_run;
   logic          r_rep_fast;
   logic [RW-1:0] w_rep_last;
   logic          w_hold;

   assign w_hold     = w_inc_level & w_fwd_level;
   assign w_rep_last = r_rep_fast ? RW'(REPEAT_RATE - 1) : RW'(REPEAT_DELAY - 1);
   assign w_rep_fire = r_rep_run & w_hold & (r_rep_cnt == w_rep_last);

   // Counter is zero in the cycle of the first pulse; the delay phase is followed by fixed-rate phases.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rep_cnt  <= '0;
         r_rep_run  <= 1'b0;
         r_rep_fast <= 1'b0;
      end else if (w_inc_rise && w_fwd_level) begin
         r_rep_cnt  <= '0;
         r_rep_run  <= 1'b1;
         r_rep_fast <= 1'b0;
      end else if (!w_hold) begin
         r_rep_cnt  <= '0;
         r_rep_run  <= 1'b0;
         r_rep_fast <= 1'b0;
      end else if (w_rep_fire) begin
         r_rep_cnt  <= '0;
         r_rep_fast <= 1'b1;
      end else if (r_rep_run) begin
         r_rep_cnt  <= r_rep_cnt + RW'(1);
      end
   end
`else
   assign w_rep_fire = 1'b0;
`endif

   assign tick       = r_tick;
   assign inc_pulse  = r_inc;
   assign forward    = w_fwd_level;
   assign load_pulse = r_load;
   assign clr_pulse  = r_clr;

endmodule

// File: tb/tb_timer_input_conditioner.sv
// Self-checking bench: expected pulse cycles go into one queue per output when stimulus is
// driven and are popped as the DUT pulses. Define TIMER_AUTO_REPEAT_EN here too for the repeat build.
module tb_timer_input_conditioner;

   localparam int unsigned TICK_DIV  = 10;
   localparam int unsigned DEB       = 16;
   localparam int unsigned REP_DELAY = 40;
   localparam int unsigned REP_RATE  = 8;
   // Input changed after edge n: synchronizer adds 2 edges, the filter DEB more, giving a new
   // debounced level after edge n+DEB+2; the registered strobe follows one cycle later.
   localparam int unsigned LVL_LAT   = DEB + 2;
   localparam int unsigned PULSE_LAT = DEB + 3;

   logic clk        = 1'b0;
   logic reset      = 1'b1;
   logic btn_inc    = 1'b0;
   logic sw_forward = 1'b0;
   logic btn_clr    = 1'b0;
   logic tick, inc_pulse, forward, load_pulse, clr_pulse;

   int unsigned cyc      = 0;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned q_tick[$];
   int unsigned q_inc[$];
   int unsigned q_load[$];
   int unsigned q_clr[$];

   timer_input_conditioner #(
      .TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEB),
      .REPEAT_DELAY(REP_DELAY), .REPEAT_RATE(REP_RATE)
   ) dut (
      .clk(clk), .reset(reset), .btn_inc(btn_inc), .sw_forward(sw_forward), .btn_clr(btn_clr),
      .tick(tick), .inc_pulse(inc_pulse), .forward(forward),
      .load_pulse(load_pulse), .clr_pulse(clr_pulse)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int unsigned actual, input int unsigned expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic check_outputs_low(input string tag);
      check({tag, "_tick"}, tick, 0);
      check({tag, "_inc"}, inc_pulse, 0);
      check({tag, "_forward"}, forward, 0);
      check({tag, "_load"}, load_pulse, 0);
      check({tag, "_clr"}, clr_pulse, 0);
   endtask

   task automatic wait_until(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: every pulse must match the next expected cycle for that output.
   always @(negedge clk) begin
      if (tick) begin
         check("tick_exclusive", {inc_pulse, load_pulse, clr_pulse}, 0);
         if (q_tick.size() == 0) check("tick_extra", tick, 0);
         else check("tick_cycle", cyc, q_tick.pop_front());
      end
      if (inc_pulse) begin
         if (q_inc.size() == 0) check("inc_extra", inc_pulse, 0);
         else check("inc_cycle", cyc, q_inc.pop_front());
      end
      if (load_pulse) begin
         if (q_load.size() == 0) check("load_extra", load_pulse, 0);
         else check("load_cycle", cyc, q_load.pop_front());
      end
      if (clr_pulse) begin
         if (q_clr.size() == 0) check("clr_extra", clr_pulse, 0);
         else check("clr_cycle", cyc, q_clr.pop_front());
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned r0, fwd_on, b, t0, h, p, ld, r2;

      // Reset state, then free-running prescaler with forward=0.
      repeat (3) @(negedge clk);
      check_outputs_low("reset");
      reset  = 1'b0;
      r0     = cyc;
      fwd_on = r0 + 55;
      for (int unsigned t = r0 + TICK_DIV; t <= fwd_on + LVL_LAT; t += TICK_DIV) q_tick.push_back(t);

      // Press while forward=0: no inc_pulse, tick cadence unchanged.
      wait_until(r0 + 5);
      btn_inc = 1'b1;
      wait_until(r0 + 30);
      btn_inc = 1'b0;
      wait_until(fwd_on);
      sw_forward = 1'b1;
      wait_until(fwd_on + LVL_LAT - 1);
      check("forward_pending", forward, 0);
      @(negedge clk);
      check("forward_set", forward, 1);

      // Bouncing press then hold with forward=1.
      wait_until(r0 + 100);
      for (int i = 0; i < 5; i++) begin
         btn_inc = 1'b1;
         repeat (3) @(negedge clk);
         btn_inc = 1'b0;
         repeat (4) @(negedge clk);
      end
      btn_inc = 1'b1;
      b  = cyc;
      t0 = b + PULSE_LAT;
      h  = t0 + 80;
      q_inc.push_back(t0);
`ifdef TIMER_AUTO_REPEAT_EN
      for (int unsigned t = t0 + REP_DELAY; t <= h + LVL_LAT; t += REP_RATE) q_inc.push_back(t);
`endif
      wait_until(h);
      btn_inc = 1'b0;
      wait_until(h + 40);
      check("inc_hold_drained", q_inc.size(), 0);

      // Short press in set mode, then switch to run: one load, ticks every TICK_DIV.
      p = cyc;
      btn_inc = 1'b1;
      q_inc.push_back(p + PULSE_LAT);
      wait_until(p + 30);
      btn_inc = 1'b0;
      wait_until(p + 60);
      sw_forward = 1'b0;
      ld = cyc + PULSE_LAT;
      q_load.push_back(ld);
      for (int unsigned k = 1; k <= 3; k++) q_tick.push_back(ld + k * TICK_DIV);

      // Clear press whose strobe lands on the 4th wrap: that tick is suppressed.
      wait_until(ld + 4 * TICK_DIV - PULSE_LAT);
      btn_clr = 1'b1;
      q_clr.push_back(ld + 4 * TICK_DIV);
      for (int unsigned k = 5; k <= 8; k++) q_tick.push_back(ld + k * TICK_DIV);
      wait_until(ld + 4 * TICK_DIV + 5);
      btn_clr = 1'b0;

      // Reset with the prescaler at 7 and every input raised.
      wait_until(ld + 8 * TICK_DIV + 7);
      reset      = 1'b1;
      btn_inc    = 1'b1;
      btn_clr    = 1'b1;
      sw_forward = 1'b1;
      #1;
      check_outputs_low("mid_reset");
      repeat (4) @(negedge clk);
      check("tick_before_reset_drained", q_tick.size(), 0);
      reset = 1'b0;
      r2    = cyc;
      q_tick.push_back(r2 + TICK_DIV);
      q_inc.push_back(r2 + PULSE_LAT);
      q_clr.push_back(r2 + PULSE_LAT);
      wait_until(r2 + LVL_LAT - 1);
      check("forward_after_reset_pending", forward, 0);
      @(negedge clk);
      check("forward_after_reset", forward, 1);

      wait_until(r2 + 60);
      check("tick_drained", q_tick.size(), 0);
      check("inc_drained", q_inc.size(), 0);
      check("load_drained", q_load.size(), 0);
      check("clr_drained", q_clr.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
